axi_wr_master: RTL and testbench
================================

Name: axi_wr_master

Overview:
- Single-outstanding AXI4 write master. Sits between the testbench/stimulus side and the AXI slave interface; sized by the shared bus parameter package.
- Accepts one write command (id, addr, len, size, burst) and issues the AW handshake.
- Streams len+1 W beats from an upstream data stream, asserting WLAST on the final beat.
- Collects the B response and reports completion with a one-cycle done pulse.

Parameters:
- AW, BUS_AW (32): address width.
- DW, BUS_DW (32): data width, multiple of 8.
- DBW, DW/8 (4): strobe width.
- IDW, BUS_IDW (4): ID width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted this cycle when both are high.
- cmd_id_i  in  IDW  transaction ID.
- cmd_addr_i  in  AW  start address.
- cmd_len_i  in  8  beats minus 1.
- cmd_size_i  in  BUS_DS  log2 bytes per beat.
- cmd_burst_i  in  2  0=FIXED, 1=INCR, 2=WRAP.
- wd_valid_i / wd_ready_o  in/out  1  upstream data handshake.
- wd_data_i  in  DW  beat data.
- wd_strb_i  in  DBW  beat strobes.
- awvalid_o, awready_i; awid_o IDW; awaddr_o AW; awlen_o 8; awsize_o 3; awburst_o 2; awlock_o 1; awcache_o 4; awprot_o 3.
- wvalid_o, wready_i; wdata_o DW; wstrb_o DBW; wlast_o 1.
- bvalid_i, bready_o; bid_i IDW; bresp_i 2.
- done_o  out  1  one-cycle completion pulse.
- done_resp_o  out  2  final response.
- done_id_o  out  IDW  ID of completed transaction.
- id_err_o  out  1  pulses with done_o when bid_i != awid_o.

Behaviour:
- Reset (rst_ni low, async): state IDLE; all valids, done_o, id_err_o = 0; cmd_ready_o = 0; registered AW fields, beat counter, done_resp_o, done_id_o = 0.
- cmd_ready_o = 1 only in IDLE.
- On command accept:
  - Register id/addr/len/size/burst.
  - Clear beat counter.
  - If cmd_size_i > log2(DBW), go to ERR; otherwise go to XFER.
- XFER state:
  - awvalid_o = 1 until the AW handshake, then 0; aw_done flag set.
  - AW fields are stable while awvalid_o is high.
  - awlock_o = 0, awprot_o = 3'b001, awcache_o = 4'b1111; these are package constants.
  - W may complete before, with, or after AW.
  - wvalid_o = wd_valid_i; wd_ready_o = wready_i. Both are combinational passthrough and gated to 0 outside XFER or after the last beat is sent.
  - wlast_o = (beat_cnt == len).
  - beat_cnt increments on each W handshake.
  - When both aw_done and the last W handshake are done (same cycle allowed), go to RESP.
- RESP state:
  - bready_o = 1.
  - On bvalid_i: capture bresp_i into done_resp_o and awid_o into done_id_o; set id_err_o = (bid_i != awid_o); pulse done_o next cycle; go to IDLE.
- ERR state:
  - No bus activity.
  - 1 cycle later: done_o = 1, done_resp_o = 2'b10 (SLVERR), done_id_o = cmd id; go to IDLE.
- done_o, done_resp_o and done_id_o are registered. done_resp_o and done_id_o hold until the next completion.
- Minimum latency, command accept to done_o, with all readies high: AW and W beat 0 in cycle 1; last W in cycle 1+len; B in the next cycle; done_o one cycle after that.
- bvalid_i outside RESP is ignored (bready_o = 0).
- WRAP and 4 KB boundary legality are the caller's responsibility; they are not checked.
- Reset mid-burst aborts immediately with valids low. This is permitted only at system reset.

Decomposition:
- Add to bus_params_pkg:
  - wr_state_e {IDLE, XFER, RESP, ERR}.
  - Burst constants BURST_FIXED/INCR/WRAP.
  - Response constants RESP_OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - Typed localparams for WR_ADDR_LOCK/PROT/CACHE, replacing macro use.
- No sub-module. Beat counter and FSM stay in one module.

Test Plan:
- INCR, id=3, addr=0x1000, len=3, size=2; all readies high; data 0xA0..0xA3, strb 0xF; bresp=0 → one AW (awlen=3, awcache=0xF, awprot=1); 4 W beats, wlast on beat 3 only; done_o pulse with resp=0, id=3, id_err=0.
- awready_i delayed 5 cycles; len=0 → the single W beat completes first, AW later; RESP entered only after AW; done_o once.
- wready_i toggling 1,0,1,0; len=7 → exactly 8 W handshakes; data order preserved; wlast on the 8th handshake; no beat dropped or duplicated.
- size=3 command → no awvalid_o/wvalid_o activity; done_o with resp=2'b10 two cycles after accept.
- bresp_i=2'b11, bid_i=5 vs awid=3 → done_resp_o=3 and id_err_o=1, both pulsing with done_o.
- rst_ni dropped mid-burst at beat 2 of 4 → all valids 0 asynchronously; after release cmd_ready_o=1 and a new command completes normally.

Source files
------------

// File: rtl/bus_params_pkg.sv
// Shared AXI bus parameters, write-master FSM states and AXI encodings.
package bus_params_pkg;

  localparam int unsigned BUS_AW  = 32;
  localparam int unsigned BUS_DW  = 32;
  localparam int unsigned BUS_IDW = 4;
  localparam int unsigned BUS_DS  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } wr_state_e;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // Fixed AW attributes: normal access, privileged data, write-back allocate.
  localparam logic       WR_ADDR_LOCK  = 1'b0;
  localparam logic [2:0] WR_ADDR_PROT  = 3'b001;
  localparam logic [3:0] WR_ADDR_CACHE = 4'b1111;

endpackage

// File: rtl/axi_wr_master.sv
// Single-outstanding AXI4 write master.
// Accepts one command (id/addr/len/size/burst), issues AW, streams len+1 W
// beats from the upstream wd_* stream (WLAST on the final beat), collects B
// and reports completion with a one-cycle done_o pulse.
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   cmd_*                     command handshake and fields
//   wd_*                      upstream write-data stream
//   aw*, w*, b*               AXI4 write address / data / response channels
//   done_o, done_resp_o,      completion pulse, final response, completed ID
//   done_id_o, id_err_o       and BID mismatch flag (pulses with done_o)
module axi_wr_master
  import bus_params_pkg::*;
#(
  parameter int unsigned AW  = BUS_AW,
  parameter int unsigned DW  = BUS_DW,
  parameter int unsigned DBW = DW / 8,
  parameter int unsigned IDW = BUS_IDW
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [IDW-1:0]    cmd_id_i,
  input  logic [AW-1:0]     cmd_addr_i,
  input  logic [7:0]        cmd_len_i,
  input  logic [BUS_DS-1:0] cmd_size_i,
  input  logic [1:0]        cmd_burst_i,

  input  logic              wd_valid_i,
  output logic              wd_ready_o,
  input  logic [DW-1:0]     wd_data_i,
  input  logic [DBW-1:0]    wd_strb_i,

  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [IDW-1:0]    awid_o,
  output logic [AW-1:0]     awaddr_o,
  output logic [7:0]        awlen_o,
  output logic [2:0]        awsize_o,
  output logic [1:0]        awburst_o,
  output logic              awlock_o,
  output logic [3:0]        awcache_o,
  output logic [2:0]        awprot_o,

  output logic              wvalid_o,
  input  logic              wready_i,
  output logic [DW-1:0]     wdata_o,
  output logic [DBW-1:0]    wstrb_o,
  output logic              wlast_o,

  input  logic              bvalid_i,
  output logic              bready_o,
  input  logic [IDW-1:0]    bid_i,
  input  logic [1:0]        bresp_i,

  output logic              done_o,
  output logic [1:0]        done_resp_o,
  output logic [IDW-1:0]    done_id_o,
  output logic              id_err_o
);

  // Largest legal AWSIZE for this data width.
  localparam int unsigned SIZE_MAX = $clog2(DBW);

  wr_state_e          state_q, state_d;

  logic               cmd_ready_q, cmd_ready_d;
  logic               awvalid_q, awvalid_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic               bready_q, bready_d;
  logic               done_q, done_d;
  logic               id_err_q, id_err_d;
  logic [IDW-1:0]     awid_q, awid_d;
  logic [AW-1:0]      awaddr_q, awaddr_d;
  logic [7:0]         awlen_q, awlen_d;
  logic [2:0]         awsize_q, awsize_d;
  logic [1:0]         awburst_q, awburst_d;
  logic [7:0]         beat_cnt_q, beat_cnt_d;
  logic [1:0]         done_resp_q, done_resp_d;
  logic [IDW-1:0]     done_id_q, done_id_d;

  logic cmd_hs, size_bad, w_active, aw_hs, w_hs, w_last, aw_fin, w_fin, b_hs;

  // Handshake decode shared by next-state and output logic.
  always_comb begin
    cmd_hs   = cmd_valid_i & cmd_ready_q;
    size_bad = cmd_size_i > BUS_DS'(SIZE_MAX);
    w_active = (state_q == XFER) & ~w_done_q;
    aw_hs    = awvalid_q & awready_i;
    w_hs     = w_active & wd_valid_i & wready_i;
    w_last   = (beat_cnt_q == awlen_q);
    aw_fin   = aw_done_q | aw_hs;
    w_fin    = w_done_q | (w_hs & w_last);
    b_hs     = bready_q & bvalid_i;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_hs) state_d = size_bad ? ERR : XFER;
      XFER: if (aw_fin && w_fin) state_d = RESP;
      RESP: if (b_hs) state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    bready_d    = (state_d == RESP);
    awvalid_d   = awvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awid_d      = awid_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    awsize_d    = awsize_q;
    awburst_d   = awburst_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;
    id_err_d    = 1'b0;
    done_resp_d = done_resp_q;
    done_id_d   = done_id_q;

    if (cmd_hs) begin
      awid_d     = cmd_id_i;
      awaddr_d   = cmd_addr_i;
      awlen_d    = cmd_len_i;
      awsize_d   = 3'(cmd_size_i);
      awburst_d  = cmd_burst_i;
      beat_cnt_d = 8'd0;
      aw_done_d  = 1'b0;
      w_done_d   = 1'b0;
      awvalid_d  = ~size_bad;
    end

    if (aw_hs) begin
      awvalid_d = 1'b0;
      aw_done_d = 1'b1;
    end

    if (w_hs) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
      if (w_last) w_done_d = 1'b1;
    end

    if ((state_q == RESP) && b_hs) begin
      done_d      = 1'b1;
      done_resp_d = bresp_i;
      done_id_d   = awid_q;
      id_err_d    = (bid_i != awid_q);
    end

    // Oversized beat: report SLVERR without touching the bus.
    if (state_q == ERR) begin
      done_d      = 1'b1;
      done_resp_d = RESP_SLVERR;
      done_id_d   = awid_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      id_err_q    <= 1'b0;
      awid_q      <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awsize_q    <= '0;
      awburst_q   <= '0;
      beat_cnt_q  <= '0;
      done_resp_q <= '0;
      done_id_q   <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      done_q      <= done_d;
      id_err_q    <= id_err_d;
      awid_q      <= awid_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      awsize_q    <= awsize_d;
      awburst_q   <= awburst_d;
      beat_cnt_q  <= beat_cnt_d;
      done_resp_q <= done_resp_d;
      done_id_q   <= done_id_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;

  assign awvalid_o = awvalid_q;
  assign awid_o    = awid_q;
  assign awaddr_o  = awaddr_q;
  assign awlen_o   = awlen_q;
  assign awsize_o  = awsize_q;
  assign awburst_o = awburst_q;
  assign awlock_o  = WR_ADDR_LOCK;
  assign awcache_o = WR_ADDR_CACHE;
  assign awprot_o  = WR_ADDR_PROT;

  // W channel is a gated passthrough of the upstream stream.
  assign wvalid_o   = wd_valid_i & w_active;
  assign wd_ready_o = wready_i & w_active;
  assign wdata_o    = wd_data_i;
  assign wstrb_o    = wd_strb_i;
  assign wlast_o    = w_active & w_last;

  assign bready_o    = bready_q;
  assign done_o      = done_q;
  assign done_resp_o = done_resp_q;
  assign done_id_o   = done_id_q;
  assign id_err_o    = id_err_q;

endmodule

// File: tb/tb_axi_wr_master.sv
// Randomized self-checking bench for axi_wr_master with a transaction-level
// reference: expected AW fields, W beat order and completion come from the
// issued command and the bench's data queue.
module tb_axi_wr_master;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned DBW = 4;
  localparam int unsigned IDW = 4;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           cmd_valid_i, cmd_ready_o;
  logic [IDW-1:0] cmd_id_i;
  logic [AW-1:0]  cmd_addr_i;
  logic [7:0]     cmd_len_i;
  logic [2:0]     cmd_size_i;
  logic [1:0]     cmd_burst_i;
  logic           wd_valid_i, wd_ready_o;
  logic [DW-1:0]  wd_data_i;
  logic [DBW-1:0] wd_strb_i;
  logic           awvalid_o, awready_i;
  logic [IDW-1:0] awid_o;
  logic [AW-1:0]  awaddr_o;
  logic [7:0]     awlen_o;
  logic [2:0]     awsize_o;
  logic [1:0]     awburst_o;
  logic           awlock_o;
  logic [3:0]     awcache_o;
  logic [2:0]     awprot_o;
  logic           wvalid_o, wready_i;
  logic [DW-1:0]  wdata_o;
  logic [DBW-1:0] wstrb_o;
  logic           wlast_o;
  logic           bvalid_i, bready_o;
  logic [IDW-1:0] bid_i;
  logic [1:0]     bresp_i;
  logic           done_o;
  logic [1:0]     done_resp_o;
  logic [IDW-1:0] done_id_o;
  logic           id_err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  axi_wr_master dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_id_i(cmd_id_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .cmd_size_i(cmd_size_i), .cmd_burst_i(cmd_burst_i),
    .wd_valid_i(wd_valid_i), .wd_ready_o(wd_ready_o),
    .wd_data_i(wd_data_i), .wd_strb_i(wd_strb_i),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awid_o(awid_o),
    .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awlock_o(awlock_o), .awcache_o(awcache_o),
    .awprot_o(awprot_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o),
    .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bid_i(bid_i), .bresp_i(bresp_i),
    .done_o(done_o), .done_resp_o(done_resp_o), .done_id_o(done_id_o),
    .id_err_o(id_err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    cmd_valid_i = 1'b0;
    wd_valid_i  = 1'b0;
    awready_i   = 1'b0;
    wready_i    = 1'b0;
    bvalid_i    = 1'b0;
  endtask

  // mode 0: all readies high, 1: random readies/valids, 2: awready late,
  // 3: wready alternating 1,0,1,0.
  task automatic run_txn(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [1:0] bresp,
                         input logic [IDW-1:0] bid, input int mode, input bit seq_data);
    logic [DW-1:0]  dq[$];
    logic [DBW-1:0] sq[$];
    int n, aw_cnt, w_idx, extra_w, b_early, bus_act, pass_err, stray, done_cyc, extra_done;
    bit is_err, accepted, done_seen;
    n = int'(len) + 1;
    is_err = (size > 3'd2);
    aw_cnt = 0; w_idx = 0; extra_w = 0; b_early = 0; bus_act = 0;
    pass_err = 0; stray = 0; done_cyc = 0; extra_done = 0; done_seen = 0;
    for (int i = 0; i < n; i++) begin
      dq.push_back(seq_data ? 32'(32'hA0 + i) : 32'($urandom));
      sq.push_back(seq_data ? 4'hF : 4'($urandom));
    end

    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_id_i = id; cmd_addr_i = addr; cmd_len_i = len;
    cmd_size_i = size; cmd_burst_i = burst;
    accepted = 0;
    for (int t = 0; t < 20; t++) begin
      #2;
      if (cmd_ready_o) begin accepted = 1; break; end
      @(negedge clk_i);
    end
    check("cmd_accept", 64'(accepted), 64'd1);
    if (!accepted) begin cmd_valid_i = 1'b0; return; end

    for (int cyc = 1; cyc <= 300 && !done_seen; cyc++) begin
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      case (mode)
        1:       awready_i = 1'($urandom);
        2:       awready_i = (cyc > 5);
        default: awready_i = 1'b1;
      endcase
      case (mode)
        1:       wready_i = 1'($urandom);
        3:       wready_i = (cyc % 2 == 1);
        default: wready_i = 1'b1;
      endcase
      if (w_idx < n) begin
        wd_valid_i = (mode == 1) ? 1'($urandom) : 1'b1;
        wd_data_i  = dq[w_idx];
        wd_strb_i  = sq[w_idx];
      end else begin
        wd_valid_i = 1'($urandom);
        wd_data_i  = 32'($urandom);
        wd_strb_i  = 4'($urandom);
      end
      bid_i = bid; bresp_i = bresp;
      if (!is_err && aw_cnt == 1 && w_idx == n)
        bvalid_i = (mode == 1) ? 1'($urandom) : 1'b1;
      else
        bvalid_i = (mode == 1) ? 1'($urandom) : 1'b0;
      #2;
      if (bvalid_i && bready_o && (aw_cnt != 1 || w_idx != n)) b_early++;
      if (is_err && (awvalid_o || wvalid_o || bready_o)) bus_act++;
      if (!is_err && w_idx < n && wvalid_o !== wd_valid_i) pass_err++;
      if (awvalid_o && awready_i) begin
        aw_cnt++;
        check("awid", 64'(awid_o), 64'(id));
        check("awaddr", 64'(awaddr_o), 64'(addr));
        check("awlen", 64'(awlen_o), 64'(len));
        check("awsize", 64'(awsize_o), 64'(size));
        check("awburst", 64'(awburst_o), 64'(burst));
        check("awcache", 64'(awcache_o), 64'hF);
        check("awprot", 64'(awprot_o), 64'h1);
        check("awlock", 64'(awlock_o), 64'h0);
      end
      if (wvalid_o && wready_i) begin
        if (w_idx < n) begin
          check("wdata", 64'(wdata_o), 64'(dq[w_idx]));
          check("wstrb", 64'(wstrb_o), 64'(sq[w_idx]));
          check("wlast", 64'(wlast_o), 64'(w_idx == n - 1));
        end else begin
          extra_w++;
        end
        w_idx++;
      end
      if (id_err_o && !done_o) stray++;
      if (done_o) begin
        done_seen = 1;
        done_cyc  = cyc;
        check("done_resp", 64'(done_resp_o), is_err ? 64'h2 : 64'(bresp));
        check("done_id", 64'(done_id_o), 64'(id));
        check("id_err", 64'(id_err_o), is_err ? 64'h0 : 64'(bid != id));
      end
    end

    check("done_seen", 64'(done_seen), 64'd1);
    check("aw_count", 64'(aw_cnt), is_err ? 64'd0 : 64'd1);
    check("w_count", 64'(w_idx), is_err ? 64'd0 : 64'(n));
    check("extra_w", 64'(extra_w), 64'd0);
    check("b_before_aw_w", 64'(b_early), 64'd0);
    check("err_bus_activity", 64'(bus_act), 64'd0);
    check("w_passthrough", 64'(pass_err), 64'd0);
    check("stray_id_err", 64'(stray), 64'd0);
    if (mode == 0) check("latency", 64'(done_cyc), is_err ? 64'd2 : 64'(n + 2));

    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      bvalid_i = 1'b0; wd_valid_i = 1'b0;
      #2;
      if (done_o) extra_done++;
    end
    check("done_single_pulse", 64'(extra_done), 64'd0);
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    logic [IDW-1:0] rid, rbid;
    drive_idle();
    cmd_id_i = '0; cmd_addr_i = '0; cmd_len_i = '0; cmd_size_i = '0; cmd_burst_i = '0;
    wd_data_i = '0; wd_strb_i = '0; bid_i = '0; bresp_i = '0;

    repeat (2) @(negedge clk_i);
    #2;
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    check("rst_awvalid", 64'(awvalid_o), 64'd0);
    check("rst_bready", 64'(bready_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_done_resp", 64'(done_resp_o), 64'd0);
    check("rst_done_id", 64'(done_id_o), 64'd0);
    check("rst_id_err", 64'(id_err_o), 64'd0);
    check("rst_awaddr", 64'(awaddr_o), 64'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    #2;
    check("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);

    run_txn(4'd3, 32'h1000, 8'd3, 3'd2, 2'd1, 2'd0, 4'd3, 0, 1'b1);
    run_txn(4'd7, 32'h2000, 8'd0, 3'd2, 2'd1, 2'd0, 4'd7, 2, 1'b0);
    run_txn(4'd1, 32'h3000, 8'd7, 3'd2, 2'd1, 2'd1, 4'd1, 3, 1'b0);
    run_txn(4'd9, 32'h4000, 8'd2, 3'd3, 2'd1, 2'd0, 4'd9, 0, 1'b0);
    run_txn(4'd3, 32'h5000, 8'd1, 3'd2, 2'd2, 2'd3, 4'd5, 0, 1'b0);

    // Reset dropped while beat 2 of 4 is offered and AW still pending.
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_id_i = 4'd6; cmd_addr_i = 32'h6000; cmd_len_i = 8'd3;
    cmd_size_i = 3'd2; cmd_burst_i = 2'd1;
    #2;
    check("rst_mid_accept", 64'(cmd_ready_o), 64'd1);
    wc = 0;
    for (int c = 0; c < 20 && wc < 2; c++) begin
      @(negedge clk_i);
      cmd_valid_i = 1'b0; awready_i = 1'b0; wready_i = 1'b1; wd_valid_i = 1'b1;
      wd_data_i = 32'($urandom);
      #2;
      if (wvalid_o && wready_i) wc++;
    end
    @(negedge clk_i);
    #2;
    check("rst_mid_pre_awvalid", 64'(awvalid_o), 64'd1);
    check("rst_mid_pre_wvalid", 64'(wvalid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_awvalid", 64'(awvalid_o), 64'd0);
    check("rst_mid_wvalid", 64'(wvalid_o), 64'd0);
    check("rst_mid_wd_ready", 64'(wd_ready_o), 64'd0);
    check("rst_mid_bready", 64'(bready_o), 64'd0);
    check("rst_mid_done", 64'(done_o), 64'd0);
    @(negedge clk_i);
    drive_idle();
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    #2;
    check("rst_mid_ready_after", 64'(cmd_ready_o), 64'd1);
    run_txn(4'd2, 32'h7000, 8'd3, 3'd2, 2'd1, 2'd0, 4'd2, 0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      rid  = 4'($urandom);
      rbid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : rid;
      run_txn(rid, 32'($urandom), 8'($urandom_range(0, 15)), 3'($urandom_range(0, 3)),
              2'($urandom_range(0, 2)), 2'($urandom), rbid, 1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
